// File: rtl/nlms_pkg.sv
// Shared types and defaults for the NLMS RFNoC block datapath.
package nlms_pkg;

    localparam int NLMS_ITEM_W  = 32;
    localparam int NLMS_SPP_W   = 16;
    localparam int NLMS_MAX_SPP = 256;

    typedef logic [NLMS_ITEM_W-1:0] item_t;
    typedef logic [NLMS_SPP_W-1:0]  spp_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } framer_state_t;

endpackage

// File: rtl/axis_skid_2.sv
// Two-entry AXI-Stream skid buffer with registered outputs and a registered
// upstream ready, so the sink's ready never reaches the source combinationally.
module axis_skid_2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] skid_data;
    logic         skid_valid;
    logic         in_ready_q;
    logic         push;

    assign push     = in_valid & in_ready_q;
    assign in_ready = in_ready_q;

    // out_* is the head entry, skid_* the second; ready drops only when both are full.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready_q <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= push;
                if (push) begin
                    skid_data <= in_data;
                end
                in_ready_q <= !push;
            end else begin
                out_valid  <= push;
                if (push) begin
                    out_data <= in_data;
                end
                skid_valid <= 1'b0;
                in_ready_q <= 1'b1;
            end
        end else begin
            if (push) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
                in_ready_q <= 1'b0;
            end else begin
                in_ready_q <= !skid_valid;
            end
        end
    end

endmodule

// File: rtl/nlms_out_framer.sv
// Output framer: cuts the NLMS core error stream into packets of cfg_spp items,
// closing a packet early (with EOB) when the core signals end of burst.
//
//   state   | meaning
//   IDLE    | next accepted item is the first of a packet; length latched then
//   IN_PKT  | packet open, item_cnt counts items already accepted
module nlms_out_framer
    import nlms_pkg::*;
#(
    parameter int ITEM_W  = NLMS_ITEM_W,
    parameter int SPP_W   = NLMS_SPP_W,
    parameter int MAX_SPP = NLMS_MAX_SPP
) (
    input  logic              ce_clk,
    input  logic              ce_rst,
    input  logic [SPP_W-1:0]  cfg_spp,
    input  logic [ITEM_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [ITEM_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_teob,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [31:0]       pkt_count,
    output logic [15:0]       short_count
);

    localparam logic [0:0]       ST_IDLE   = IDLE;
    localparam logic [0:0]       ST_IN_PKT = IN_PKT;
    localparam int               PAY_W     = ITEM_W + 2;
    localparam logic [SPP_W-1:0] SPP_ONE   = SPP_W'(1);
    localparam logic [SPP_W-1:0] SPP_MAX   = SPP_W'(MAX_SPP);

    logic [0:0]       state;
    logic [SPP_W-1:0] spp_lat;
    logic [SPP_W-1:0] item_cnt;
    logic [SPP_W-1:0] spp_req;
    logic [SPP_W-1:0] spp_eff;
    logic [SPP_W-1:0] cnt_cur;
    logic             s_ready;
    logic             in_accept;
    logic             len_last;
    logic             item_last;
    logic             short_pkt;
    logic             m_fire;
    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] out_pay;

    always_comb begin
        spp_req = cfg_spp;
        if (cfg_spp == '0) begin
            spp_req = SPP_ONE;
        end else if (cfg_spp > SPP_MAX) begin
            spp_req = SPP_MAX;
        end
    end

    // On the first item of a packet the live (clamped) cfg_spp decides; afterwards the latch does.
    assign spp_eff   = (state == ST_IDLE) ? spp_req : spp_lat;
    assign cnt_cur   = (state == ST_IDLE) ? '0 : item_cnt;
    assign len_last  = (cnt_cur == spp_eff - SPP_ONE);
    assign item_last = len_last | s_axis_tlast;
    assign short_pkt = s_axis_tlast & ~len_last;
    assign in_accept = s_axis_tvalid & s_ready;
    assign s_axis_tready = s_ready;

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            state    <= ST_IDLE;
            spp_lat  <= '0;
            item_cnt <= '0;
        end else if (in_accept) begin
            if (state == ST_IDLE) begin
                spp_lat <= spp_req;
            end
            if (item_last) begin
                state    <= ST_IDLE;
                item_cnt <= '0;
            end else begin
                state    <= ST_IN_PKT;
                item_cnt <= cnt_cur + SPP_ONE;
            end
        end
    end

    assign in_pay = {s_axis_tdata, item_last, s_axis_tlast};

    axis_skid_2 #(
        .W(PAY_W)
    ) u_skid (
        .clk      (ce_clk),
        .rst      (ce_rst),
        .in_data  (in_pay),
        .in_valid (s_axis_tvalid),
        .in_ready (s_ready),
        .out_data (out_pay),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready)
    );

    assign m_axis_tdata = out_pay[PAY_W-1:2];
    assign m_axis_tlast = out_pay[1];
    assign m_axis_teob  = out_pay[0];
    assign m_fire       = m_axis_tvalid & m_axis_tready;

    // Packets are counted as they leave; early closes are counted as they are framed.
    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            pkt_count   <= '0;
            short_count <= '0;
        end else begin
            if (m_fire && m_axis_tlast) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if (in_accept && short_pkt && (short_count != 16'hFFFF)) begin
                short_count <= short_count + 16'd1;
            end
        end
    end

endmodule
